// File: rtl/sdio_irq_pkg.sv
// Shared constants and types for the SD host interrupt controller:
// register indices, COAL/CNT field positions and the coalescing state encoding.
package sdio_irq_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_STAT_EN = 3'd1;
    localparam logic [2:0] REG_SIG_EN  = 3'd2;
    localparam logic [2:0] REG_FORCE   = 3'd3;
    localparam logic [2:0] REG_COAL    = 3'd4;
    localparam logic [2:0] REG_RAW     = 3'd5;
    localparam logic [2:0] REG_CNT     = 3'd6;
    localparam int         NUM_REGS    = 7;

    localparam int COAL_THRESH_LSB = 0;
    localparam int COAL_THRESH_W   = 8;
    localparam int COAL_TMO_LSB    = 8;
    localparam int COAL_TMO_W      = 16;
    localparam logic [31:0] COAL_MASK = 32'h00FF_FFFF;

    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_PEND   = 2'd1,
        IRQ_ASSERT = 2'd2
    } irq_state_e;

    // Mask of implemented source bits inside a 32-bit register.
    function automatic logic [31:0] src_mask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

endpackage

// File: rtl/sdio_irq_if.sv
// Register-bank access bus between the SD register decoder and the interrupt block.
interface sdio_irq_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          reg_wr;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic [DW-1:0] reg_rdata;

    modport master (output reg_wr, output reg_addr, output reg_wdata, input reg_rdata);
    modport slave  (input reg_wr, input reg_addr, input reg_wdata, output reg_rdata);
endinterface

// File: rtl/sdio_irq_coal.sv
// Interrupt coalescing FSM: holds off irq until enough events arrive or the
// pending condition has aged past the timeout.
module sdio_irq_coal
    import sdio_irq_pkg::*;
(
    input  logic        sd_clk,
    input  logic        rstn,
    input  logic        pending,
    input  logic        new_evt,
    input  logic [7:0]  thresh,
    input  logic [15:0] timeout,
    output logic        irq,
    output irq_state_e  state,
    output logic [7:0]  evt_cnt,
    output logic [15:0] timer
);

    irq_state_e  state_q, state_d;
    logic        irq_q, irq_d;
    logic [7:0]  evt_cnt_q, evt_cnt_d;
    logic [15:0] timer_q, timer_d;
    logic [8:0]  evt_sum;
    logic [7:0]  evt_sat;
    logic [15:0] timer_sat;
    logic        thresh_hit;
    logic        tmo_hit;

    always_comb begin
        state_d   = state_q;
        evt_cnt_d = evt_cnt_q;
        timer_d   = timer_q;

        evt_sum    = {1'b0, evt_cnt_q} + 9'(new_evt);
        evt_sat    = (evt_cnt_q == 8'hFF) ? 8'hFF : evt_cnt_q + 8'(new_evt);
        timer_sat  = (timer_q == 16'hFFFF) ? 16'hFFFF : timer_q + 16'd1;
        thresh_hit = (thresh != 8'd0) && (evt_sum >= {1'b0, thresh});
        tmo_hit    = (timeout != 16'd0) && (timer_q >= timeout - 16'd1);

        unique case (state_q)
            IRQ_IDLE: begin
                // The event that raises pending is counted here, before PEND is reached.
                evt_cnt_d = evt_sat;
                if (pending) begin
                    state_d = (thresh == 8'd0) ? IRQ_ASSERT : IRQ_PEND;
                end
            end
            IRQ_PEND: begin
                evt_cnt_d = evt_sat;
                timer_d   = timer_sat;
                if (!pending) begin
                    state_d = IRQ_IDLE;
                end else if (thresh_hit || tmo_hit) begin
                    state_d = IRQ_ASSERT;
                end
            end
            IRQ_ASSERT: begin
                if (!pending) begin
                    state_d = IRQ_IDLE;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase

        if ((state_d == IRQ_IDLE) && (state_q != IRQ_IDLE)) begin
            evt_cnt_d = 8'd0;
            timer_d   = 16'd0;
        end

        irq_d = (state_d == IRQ_ASSERT);
    end

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IRQ_IDLE;
            irq_q     <= 1'b0;
            evt_cnt_q <= 8'd0;
            timer_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            evt_cnt_q <= evt_cnt_d;
            timer_q   <= timer_d;
        end
    end

    assign irq     = irq_q;
    assign state   = state_q;
    assign evt_cnt = evt_cnt_q;
    assign timer   = timer_q;

endmodule

// File: rtl/sdio_irq_ctrl.sv
// SD host interrupt controller: W1C status, status/signal enables, software
// force, event edge detect and a coalescing stage driving the host irq line.
module sdio_irq_ctrl
    import sdio_irq_pkg::*;
#(
    parameter int          NUM_SRC = 16,
    parameter int          DW      = 8,
    parameter int          AW      = 8,
    parameter int unsigned BASE    = 64
) (
    input  logic               sd_clk,
    input  logic               rstn,
    sdio_irq_if.slave          bus,
    input  logic [NUM_SRC-1:0] src_evt,
    output logic               irq,
    output logic [1:0]         irq_state
);

    localparam logic [31:0] SRC_MASK  = src_mask(NUM_SRC);
    localparam logic [31:0] LANE_MASK = (DW == 32) ? 32'hFFFF_FFFF : ((32'd1 << DW) - 32'd1);

    // Registers are kept 32 bits wide; bits above NUM_SRC are masked to zero and fold away.
    logic [31:0] status_q, status_d;
    logic [31:0] stat_en_q, stat_en_d;
    logic [31:0] sig_en_q, sig_en_d;
    logic [31:0] coal_q, coal_d;
    logic [31:0] src_d1_q, src_d1_d;

    logic [31:0] addr_ext, off;
    logic        in_map, wr_en;
    logic [2:0]  idx;
    logic [4:0]  lane_sh;
    logic [31:0] wr_word, wr_mask;
    logic [31:0] src_ext, w1c_vec, force_vec, set_vec;
    logic [31:0] rd_word;
    logic        pending, new_evt;

    logic        coal_irq;
    irq_state_e  coal_state;
    logic [7:0]  evt_cnt;
    logic [15:0] timer;

    always_comb begin
        addr_ext = 32'(bus.reg_addr);
        off      = addr_ext - BASE;
        in_map   = (addr_ext >= BASE) && (off < 32'(4 * NUM_REGS));
        idx      = off[4:2];
        lane_sh  = {off[1:0], 3'b000};
        wr_en    = bus.reg_wr && in_map;
        wr_word  = 32'(bus.reg_wdata) << lane_sh;
        wr_mask  = LANE_MASK << lane_sh;
    end

    always_comb begin
        src_ext   = 32'(src_evt);
        w1c_vec   = (wr_en && idx == REG_STATUS) ? (wr_word & SRC_MASK) : 32'd0;
        force_vec = (wr_en && idx == REG_FORCE)  ? (wr_word & SRC_MASK) : 32'd0;
        set_vec   = (src_ext & ~src_d1_q & stat_en_q) | force_vec;
        // Set wins over a same-cycle W1C.
        status_d  = (status_q & ~w1c_vec) | set_vec;
        src_d1_d  = src_ext;

        stat_en_d = stat_en_q;
        sig_en_d  = sig_en_q;
        coal_d    = coal_q;
        if (wr_en && idx == REG_STAT_EN) begin
            stat_en_d = ((stat_en_q & ~wr_mask) | (wr_word & wr_mask)) & SRC_MASK;
        end
        if (wr_en && idx == REG_SIG_EN) begin
            sig_en_d = ((sig_en_q & ~wr_mask) | (wr_word & wr_mask)) & SRC_MASK;
        end
        if (wr_en && idx == REG_COAL) begin
            coal_d = ((coal_q & ~wr_mask) | (wr_word & wr_mask)) & COAL_MASK;
        end

        pending = |(status_q & sig_en_q);
        new_evt = |(set_vec & sig_en_q);
    end

    always_comb begin
        rd_word = 32'd0;
        if (in_map) begin
            unique case (idx)
                REG_STATUS:  rd_word = status_q;
                REG_STAT_EN: rd_word = stat_en_q;
                REG_SIG_EN:  rd_word = sig_en_q;
                REG_COAL:    rd_word = coal_q;
                REG_RAW:     rd_word = src_ext;
                REG_CNT:     rd_word = {timer, 8'h00, evt_cnt};
                default:     rd_word = 32'd0;
            endcase
        end
        bus.reg_rdata = rd_word[lane_sh +: DW];
    end

    always_ff @(posedge sd_clk or negedge rstn) begin
        if (!rstn) begin
            status_q  <= 32'd0;
            stat_en_q <= 32'd0;
            sig_en_q  <= 32'd0;
            coal_q    <= 32'd0;
            src_d1_q  <= 32'd0;
        end else begin
            status_q  <= status_d;
            stat_en_q <= stat_en_d;
            sig_en_q  <= sig_en_d;
            coal_q    <= coal_d;
            src_d1_q  <= src_d1_d;
        end
    end

    sdio_irq_coal u_coal (
        .sd_clk  (sd_clk),
        .rstn    (rstn),
        .pending (pending),
        .new_evt (new_evt),
        .thresh  (coal_q[COAL_THRESH_LSB +: COAL_THRESH_W]),
        .timeout (coal_q[COAL_TMO_LSB +: COAL_TMO_W]),
        .irq     (coal_irq),
        .state   (coal_state),
        .evt_cnt (evt_cnt),
        .timer   (timer)
    );

    assign irq       = coal_irq;
    assign irq_state = coal_state;

endmodule
